// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared widths, FSM encodings and helpers for the MBus transmit arbiter.
package mbus_tx_arbiter_pkg;

  localparam int MBUS_ADDR_WIDTH = 32;
  localparam int MBUS_DATA_WIDTH = 32;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE = 3'd0;
  localparam tx_state_t ST_SEND = 3'd1;
  localparam tx_state_t ST_DROP = 3'd2;
  localparam tx_state_t ST_NEXT = 3'd3;
  localparam tx_state_t ST_RESP = 3'd4;
  localparam tx_state_t ST_RACK = 3'd5;

  // States in which a bus-side failure aborts the message in flight.
  function automatic logic is_abort_state(input tx_state_t st);
    return (st == ST_SEND) || (st == ST_DROP) || (st == ST_NEXT);
  endfunction

endpackage

// File: rtl/mbus_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mbus_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int            slot;
  logic [IW-1:0] slot_idx;

  // Walk offsets from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      slot = int'(ptr) + k;
      if (slot >= N) slot = slot - N;
      slot_idx = IW'(slot);
      if (req[slot_idx]) begin
        grant           = '0;
        grant[slot_idx] = 1'b1;
        idx             = slot_idx;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Shares one MBus TX port among NUM_REQ requesters; owns the word, lock and
// response handshakes and reports completion back to the grantee.
module mbus_tx_arbiter
  import mbus_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = MBUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = MBUS_DATA_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PEND,
  input  logic [NUM_REQ-1:0]            REQ_PRIO,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [NUM_REQ-1:0]            DONE,
  output logic                          DONE_FAIL,
  output logic [ADDR_WIDTH-1:0]         TX_ADDR,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_PEND,
  output logic                          PRIORITY,
  output logic                          TX_REQ,
  input  logic                          TX_ACK,
  input  logic                          TX_SUCC,
  input  logic                          TX_FAIL,
  output logic                          TX_RESP_ACK,
  output logic                          BUSY,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID
);

  localparam int IW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_addr[gi] = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign slot_data[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  tx_state_t             state_reg;
  logic [IW-1:0]         rr_ptr_reg;
  logic [IW-1:0]         grant_id_reg;
  logic [ADDR_WIDTH-1:0] tx_addr_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_pend_reg;
  logic                  prio_reg;
  logic                  tx_req_reg;
  logic                  resp_ack_reg;
  logic                  fail_reg;
  logic                  busy_reg;
  logic                  done_fail_reg;
  logic [NUM_REQ-1:0]    req_ack_reg;
  logic [NUM_REQ-1:0]    done_reg;

  // Priority requests, when present, hide all ordinary ones from arbitration.
  logic [NUM_REQ-1:0] prio_valid;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  assign prio_valid = REQ_PRIO & REQ_VALID;
  assign cand       = (|prio_valid) ? prio_valid : REQ_VALID;

  mbus_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_data;
  logic                  pick_pend;
  logic                  pick_prio;

  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_addr = pick_addr | slot_addr[i];
        pick_data = pick_data | slot_data[i];
      end
    end
    pick_pend = |(pick_grant & REQ_PEND);
    pick_prio = |(pick_grant & REQ_PRIO);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      tx_addr_reg   <= '0;
      tx_data_reg   <= '0;
      tx_pend_reg   <= 1'b0;
      prio_reg      <= 1'b0;
      tx_req_reg    <= 1'b0;
      resp_ack_reg  <= 1'b0;
      fail_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_fail_reg <= 1'b0;
      req_ack_reg   <= '0;
      done_reg      <= '0;
    end else begin
      req_ack_reg   <= '0;
      done_reg      <= '0;
      done_fail_reg <= 1'b0;
      // A failure before the response phase wins over any ack in the same cycle.
      if (is_abort_state(state_reg) && TX_FAIL) begin
        tx_req_reg   <= 1'b0;
        fail_reg     <= 1'b1;
        resp_ack_reg <= 1'b1;
        state_reg    <= ST_RACK;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (pick_any) begin
              tx_addr_reg  <= pick_addr;
              tx_data_reg  <= pick_data;
              tx_pend_reg  <= pick_pend;
              prio_reg     <= pick_prio;
              grant_id_reg <= pick_idx;
              fail_reg     <= 1'b0;
              tx_req_reg   <= 1'b1;
              busy_reg     <= 1'b1;
              state_reg    <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (TX_ACK) begin
              tx_req_reg                <= 1'b0;
              req_ack_reg[grant_id_reg] <= 1'b1;
              state_reg                 <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (!TX_ACK) state_reg <= tx_pend_reg ? ST_NEXT : ST_RESP;
          end
          ST_NEXT: begin
            // Message is locked: only the grantee may supply the next word.
            if (REQ_VALID[grant_id_reg]) begin
              tx_addr_reg <= slot_addr[grant_id_reg];
              tx_data_reg <= slot_data[grant_id_reg];
              tx_pend_reg <= REQ_PEND[grant_id_reg];
              tx_req_reg  <= 1'b1;
              state_reg   <= ST_SEND;
            end
          end
          ST_RESP: begin
            if (TX_SUCC || TX_FAIL) begin
              fail_reg     <= TX_FAIL;
              resp_ack_reg <= 1'b1;
              state_reg    <= ST_RACK;
            end
          end
          ST_RACK: begin
            if (!TX_SUCC && !TX_FAIL) begin
              resp_ack_reg           <= 1'b0;
              done_reg[grant_id_reg] <= 1'b1;
              done_fail_reg          <= fail_reg;
              busy_reg               <= 1'b0;
              if (grant_id_reg == IW'(NUM_REQ - 1)) rr_ptr_reg <= '0;
              else                                   rr_ptr_reg <= grant_id_reg + 1'b1;
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign REQ_ACK     = req_ack_reg;
  assign DONE        = done_reg;
  assign DONE_FAIL   = done_fail_reg;
  assign TX_ADDR     = tx_addr_reg;
  assign TX_DATA     = tx_data_reg;
  assign TX_PEND     = tx_pend_reg;
  assign PRIORITY    = prio_reg;
  assign TX_REQ      = tx_req_reg;
  assign TX_RESP_ACK = resp_ack_reg;
  assign BUSY        = busy_reg;
  assign GRANT_ID    = grant_id_reg;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Bench for mbus_tx_arbiter: requester and bus-controller models with a
// scoreboard of expected words and completions.
module tb_mbus_tx_arbiter;
  import mbus_tx_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = MBUS_ADDR_WIDTH;
  localparam int DW = MBUS_DATA_WIDTH;
  localparam int M_OK = 0, M_FAIL = 1, M_HOLD = 2;

  logic CLK = 1'b0;
  logic RESET;
  logic [NR-1:0]    REQ_VALID, REQ_PEND, REQ_PRIO, REQ_ACK, DONE;
  logic [NR*AW-1:0] REQ_ADDR;
  logic [NR*DW-1:0] REQ_DATA;
  logic             DONE_FAIL, TX_PEND, PRIORITY, TX_REQ, TX_RESP_ACK, BUSY;
  logic [AW-1:0]    TX_ADDR;
  logic [DW-1:0]    TX_DATA;
  logic             TX_ACK, TX_SUCC, TX_FAIL;
  logic [1:0]       GRANT_ID;

  always #5 CLK = ~CLK;

  mbus_tx_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_PEND(REQ_PEND), .REQ_PRIO(REQ_PRIO), .REQ_ACK(REQ_ACK),
    .DONE(DONE), .DONE_FAIL(DONE_FAIL),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .PRIORITY(PRIORITY),
    .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK), .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          pend;
    logic          prio;
  } rq_word_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          pend;
    logic          prio;
    int            gid;
    int            mode;
    int            delay;
  } exp_word_t;

  typedef struct {
    int   gid;
    logic fail;
  } exp_done_t;

  rq_word_t  rq_q [NR][$];
  exp_word_t exp_q[$];
  exp_done_t done_q[$];
  int ack_cnt [NR];
  int ack_exp [NR];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic pend, input logic prio);
    rq_word_t w;
    w.addr = a; w.data = d; w.pend = pend; w.prio = prio;
    rq_q[r].push_back(w);
  endtask

  task automatic exp_word(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic pend, input logic prio, input int mode);
    exp_word_t e;
    e.addr = a; e.data = d; e.pend = pend; e.prio = prio;
    e.gid = g; e.mode = mode; e.delay = int'($urandom_range(0, 2));
    exp_q.push_back(e);
    if (mode == M_OK) ack_exp[g]++;
  endtask

  task automatic exp_done(input int g, input logic fail);
    exp_done_t x;
    x.gid = g; x.fail = fail;
    done_q.push_back(x);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0 || BUSY) && n < 3000) begin
      @(posedge CLK); #2;
      n++;
    end
    check_val({tag, "_drain"}, 64'(n < 3000), 64'd1);
    for (int i = 0; i < NR; i++)
      check_val($sformatf("%s_acks%0d", tag, i), ack_cnt[i], ack_exp[i]);
  endtask

  // Requester models and completion monitor, updated away from the active edge.
  initial begin : requesters
    rq_word_t  w;
    exp_done_t x;
    REQ_VALID = '0; REQ_PEND = '0; REQ_PRIO = '0; REQ_ADDR = '0; REQ_DATA = '0;
    for (int i = 0; i < NR; i++) begin ack_cnt[i] = 0; ack_exp[i] = 0; end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < NR; i++) begin
        if (REQ_ACK[i]) begin
          ack_cnt[i]++;
          if (rq_q[i].size() > 0) rq_q[i].delete(0);
        end
      end
      if (DONE != '0) begin
        if (done_q.size() == 0) begin
          check_val("done_unexpected", DONE, '0);
        end else begin
          x = done_q.pop_front();
          $display("done gid=%0d fail=%0d", x.gid, DONE_FAIL);
          check_val("done_id", DONE, 64'(1) << x.gid);
          check_val("done_fail", DONE_FAIL, x.fail);
        end
        for (int i = 0; i < NR; i++)
          if (DONE[i] && DONE_FAIL) rq_q[i].delete();
      end
      for (int i = 0; i < NR; i++) begin
        if (rq_q[i].size() > 0) begin
          w = rq_q[i][0];
          REQ_VALID[i] = 1'b1;
          REQ_ADDR[i*AW +: AW] = w.addr;
          REQ_DATA[i*DW +: DW] = w.data;
          REQ_PEND[i] = w.pend;
          REQ_PRIO[i] = w.prio;
        end else begin
          REQ_VALID[i] = 1'b0;
          REQ_PEND[i]  = 1'b0;
          REQ_PRIO[i]  = 1'b0;
        end
      end
    end
  end

  task automatic serve_word();
    exp_word_t e;
    int n;
    if (exp_q.size() == 0) begin
      check_val("exp_q_size", exp_q.size(), 1);
      e.addr = TX_ADDR; e.data = TX_DATA; e.pend = TX_PEND; e.prio = PRIORITY;
      e.gid = int'(GRANT_ID); e.mode = M_OK; e.delay = 0;
    end else begin
      e = exp_q.pop_front();
    end
    $display("word gid=%0d addr=0x%0h data=0x%0h pend=%0d prio=%0d",
             GRANT_ID, TX_ADDR, TX_DATA, TX_PEND, PRIORITY);
    check_val("tx_addr", TX_ADDR, e.addr);
    check_val("tx_data", TX_DATA, e.data);
    check_val("tx_pend", TX_PEND, e.pend);
    check_val("priority", PRIORITY, e.prio);
    check_val("grant_id", GRANT_ID, e.gid);
    if (e.mode == M_HOLD) begin
      n = 0;
      while (TX_REQ && n < 200) begin @(posedge CLK); #1; n++; end
      check_val("hold_drop", TX_REQ, 0);
      return;
    end
    if (e.mode == M_FAIL) begin
      TX_FAIL = 1'b1;
      n = 0;
      while (!TX_RESP_ACK && n < 50) begin @(posedge CLK); #1; n++; end
      check_val("abort_resp_ack", TX_RESP_ACK, 1);
      check_val("abort_tx_req", TX_REQ, 0);
      check_val("abort_no_ack", REQ_ACK, '0);
      TX_FAIL = 1'b0;
      n = 0;
      while (TX_RESP_ACK && n < 50) begin @(posedge CLK); #1; n++; end
      check_val("abort_resp_drop", TX_RESP_ACK, 0);
      return;
    end
    repeat (e.delay) begin @(posedge CLK); #1; end
    TX_ACK = 1'b1;
    n = 0;
    while (TX_REQ && n < 50) begin @(posedge CLK); #1; n++; end
    check_val("tx_req_drop", TX_REQ, 0);
    check_val("req_ack", REQ_ACK, 64'(1) << e.gid);
    @(posedge CLK); #1;
    TX_ACK = 1'b0;
    if (!e.pend) begin
      repeat (2) begin @(posedge CLK); #1; end
      TX_SUCC = 1'b1;
      n = 0;
      while (!TX_RESP_ACK && n < 50) begin @(posedge CLK); #1; n++; end
      check_val("resp_ack", TX_RESP_ACK, 1);
      TX_SUCC = 1'b0;
      n = 0;
      while (TX_RESP_ACK && n < 50) begin @(posedge CLK); #1; n++; end
      check_val("resp_ack_drop", TX_RESP_ACK, 0);
    end
  endtask

  // Bus-controller model.
  initial begin : bus
    TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (TX_REQ && !RESET) serve_word();
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_tx_req", TX_REQ, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_grant", GRANT_ID, 0);
    check_val("rst_addr", TX_ADDR, 0);
    check_val("rst_data", TX_DATA, 0);
    check_val("rst_req_ack", REQ_ACK, 0);
    check_val("rst_done", DONE, 0);
    check_val("rst_resp_ack", TX_RESP_ACK, 0);
    @(posedge CLK); #3;
    RESET = 1'b0;

    // Round-robin over all four requesters, req0 queuing two messages.
    @(posedge CLK); #2;
    add_word(0, 'h100, 'hA0, 1'b0, 1'b0);
    add_word(0, 'h104, 'hA4, 1'b0, 1'b0);
    add_word(1, 'h110, 'hB0, 1'b0, 1'b0);
    add_word(2, 'h120, 'hC0, 1'b0, 1'b0);
    add_word(3, 'h130, 'hD0, 1'b0, 1'b0);
    exp_word(0, 'h100, 'hA0, 1'b0, 1'b0, M_OK); exp_done(0, 1'b0);
    exp_word(1, 'h110, 'hB0, 1'b0, 1'b0, M_OK); exp_done(1, 1'b0);
    exp_word(2, 'h120, 'hC0, 1'b0, 1'b0, M_OK); exp_done(2, 1'b0);
    exp_word(3, 'h130, 'hD0, 1'b0, 1'b0, M_OK); exp_done(3, 1'b0);
    exp_word(0, 'h104, 'hA4, 1'b0, 1'b0, M_OK); exp_done(0, 1'b0);
    wait_quiet("rr");

    // Single word, including the one-cycle request latency.
    @(posedge CLK); #2;
    add_word(0, 'h12, 'hDEADBEEF, 1'b0, 1'b0);
    exp_word(0, 'h12, 'hDEADBEEF, 1'b0, 1'b0, M_OK); exp_done(0, 1'b0);
    @(negedge CLK); #1;
    check_val("lat_before", TX_REQ, 0);
    @(posedge CLK); #2;
    check_val("lat_tx_req", TX_REQ, 1);
    check_val("lat_busy", BUSY, 1);
    wait_quiet("single");

    // Locked three-word message from req1 while req2 waits.
    @(posedge CLK); #2;
    add_word(1, 'h20, 'h200, 1'b1, 1'b0);
    add_word(1, 'h24, 'h204, 1'b1, 1'b0);
    add_word(1, 'h28, 'h208, 1'b0, 1'b0);
    add_word(2, 'h30, 'h300, 1'b0, 1'b0);
    exp_word(1, 'h20, 'h200, 1'b1, 1'b0, M_OK);
    exp_word(1, 'h24, 'h204, 1'b1, 1'b0, M_OK);
    exp_word(1, 'h28, 'h208, 1'b0, 1'b0, M_OK); exp_done(1, 1'b0);
    exp_word(2, 'h30, 'h300, 1'b0, 1'b0, M_OK); exp_done(2, 1'b0);
    wait_quiet("multi");

    // Failure on the second word of a pending message from req3.
    @(posedge CLK); #2;
    add_word(3, 'h40, 'h400, 1'b1, 1'b0);
    add_word(3, 'h44, 'h404, 1'b0, 1'b0);
    exp_word(3, 'h40, 'h400, 1'b1, 1'b0, M_OK);
    exp_word(3, 'h44, 'h404, 1'b0, 1'b0, M_FAIL); exp_done(3, 1'b1);
    wait_quiet("abort");

    // Priority request beats the requester the pointer favours.
    @(posedge CLK); #2;
    add_word(0, 'h50, 'h500, 1'b0, 1'b0);
    add_word(3, 'h60, 'h600, 1'b0, 1'b1);
    exp_word(3, 'h60, 'h600, 1'b0, 1'b1, M_OK); exp_done(3, 1'b0);
    exp_word(0, 'h50, 'h500, 1'b0, 1'b0, M_OK); exp_done(0, 1'b0);
    wait_quiet("prio");

    // Asynchronous reset while a word is being offered.
    @(posedge CLK); #2;
    add_word(2, 'h70, 'h700, 1'b0, 1'b0);
    exp_word(2, 'h70, 'h700, 1'b0, 1'b0, M_HOLD);
    n = 0;
    while (!TX_REQ && n < 50) begin @(posedge CLK); #2; n++; end
    check_val("hold_tx_req", TX_REQ, 1);
    #1;
    RESET = 1'b1;
    #1;
    check_val("arst_tx_req", TX_REQ, 0);
    check_val("arst_busy", BUSY, 0);
    check_val("arst_grant", GRANT_ID, 0);
    check_val("arst_addr", TX_ADDR, 0);
    check_val("arst_data", TX_DATA, 0);
    rq_q[2].delete();
    repeat (2) @(posedge CLK);
    #3;
    RESET = 1'b0;
    @(posedge CLK); #2;
    add_word(1, 'h80, 'h800, 1'b0, 1'b0);
    add_word(0, 'h90, 'h900, 1'b0, 1'b0);
    exp_word(0, 'h90, 'h900, 1'b0, 1'b0, M_OK); exp_done(0, 1'b0);
    exp_word(1, 'h80, 'h800, 1'b0, 1'b0, M_OK); exp_done(1, 1'b0);
    wait_quiet("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
